ram64_copier: RTL and testbench
===============================

# ram64_copier

Sequencing initiator that drives the RAM64 port (addr/in/ld in, out back) to copy or fill a block of 16-bit words without CPU involvement. Accepts one command per start pulse, walks the address range word by word, and reports completion with a one-cycle done pulse and a 16-bit running checksum. Sits between the control logic and a RAM64 instance, owning that instance's address, data-in and load lines while busy.

## Interface

- ADDR_W, 6, RAM address width (64 words)
- DATA_W, 16, RAM word width
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  0 = copy src→dst, 1 = fill dst with pattern
- src  in  ADDR_W  first source address (copy mode)
- dst  in  ADDR_W  first destination address
- len  in  ADDR_W+1  word count, 0..64
- pattern  in  DATA_W  fill value (fill mode)
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle completion pulse
- checksum  out  DATA_W  sum mod 2^16 of all words written by the last command
- mem_addr  out  ADDR_W  to RAM64 addr
- mem_in  out  DATA_W  to RAM64 in
- mem_ld  out  1  to RAM64 ld
- mem_out  in  DATA_W  from RAM64 out (combinational read of mem_addr)

## Operation

- States: IDLE, READ, WRITE, DONE. All outputs decoded from registers only; no combinational path from command inputs to mem_*.
- IDLE: busy=0, mem_ld=0. start=1 with len≠0: latch mode, src_ptr, dst_ptr, count=len, pattern; clear checksum; go READ (copy) or WRITE (fill). start=1 with len=0: clear checksum, go DONE, no memory access. start outside IDLE ignored.
- READ: mem_addr=src_ptr, mem_ld=0. At edge: data_reg←mem_out; go WRITE.
- WRITE: mem_addr=dst_ptr, mem_in=data_reg (copy) or pattern (fill), mem_ld=1. At edge: checksum+=written word (mod 2^16); src_ptr, dst_ptr +1 mod 64; count−1. count reaching 0 → DONE; else copy → READ, fill → WRITE.
- DONE: done=1, busy=1, mem_ld=0; next edge → IDLE.
- Pointers wrap 63→0 silently; len=64 touches every word exactly once.
- Overlapping ranges: strictly ascending word-by-word order, no correction; dst=src+1 with len=N propagates word src into all N destinations.
- checksum holds its value from DONE until the next accepted start.

## Timing

- Reset values (asserted asynchronously on rst_n low): state IDLE, busy 0, done 0, mem_ld 0, mem_addr 0, mem_in 0, checksum 0, all pointers/count 0.
- Reset mid-command: mem_ld drops immediately; words already written stay; no done pulse.
- start sampled at edge k: busy high from k+1.
- Copy, N words: 2N cycles in READ/WRITE; done high in cycle k+2N+1; IDLE at k+2N+2.
- Fill, N words: N WRITE cycles; done in cycle k+N+1.
- len=0: done in cycle k+1.
- Back-to-back: start held high through DONE is accepted at the first IDLE edge (cycle after done).
- RAM write occurs on the rising edge ending each WRITE cycle.

## Test plan

- Preload RAM[0..3]=1,2,3,4; copy src=0 dst=10 len=4 → RAM[10..13]=1,2,3,4, done exactly 9 cycles after start edge, checksum=10, mem_ld high only in 4 cycles.
- Fill dst=62 pattern=0xA5A5 len=4 → RAM[62],RAM[63],RAM[0],RAM[1]=0xA5A5, other words unchanged, checksum=0x9694, done 5 cycles after start.
- len=0 start → done pulse next cycle, mem_ld never asserted, checksum=0.
- Preload RAM[5]=7, RAM[6..8]=0; copy src=5 dst=6 len=3 → RAM[6..8]=7,7,7, checksum=21.
- Start copy len=8, deassert rst_n after third WRITE → busy/mem_ld low immediately, only first 3 destination words written, no done; after release a new len=1 command completes normally.
- Pulse start with different args while busy → ignored; RAM and checksum match first command only.

Source files
------------

// File: rtl/ram64_copier_if.sv
// RAM64 port bundle: the copier drives address/data/load, the RAM returns its
// combinational read of the addressed word.
interface ram64_copier_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_in;
    logic              mem_ld;
    logic [DATA_W-1:0] mem_out;

    modport master (
        output mem_addr,
        output mem_in,
        output mem_ld,
        input  mem_out
    );

    modport slave (
        input  mem_addr,
        input  mem_in,
        input  mem_ld,
        output mem_out
    );
endinterface

// File: rtl/ram64_copier.sv
// Block copy/fill sequencer for a 64-word RAM: walks the address range one word
// per WRITE cycle, keeps a mod-2^16 checksum of written words, pulses done at the end.
module ram64_copier #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [DATA_W-1:0] pattern_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] checksum_o,
    ram64_copier_if.master    mem
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              ld_q, ld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State and registered-output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            ld_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; memory-side outputs are decoded from the next state so
    // they are flop outputs during the cycle they apply to.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ld_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sum_d = '0;
                    if (len_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        mode_d  = mode_i;
                        src_d   = src_i;
                        dst_d   = dst_i;
                        cnt_d   = len_i;
                        pat_d   = pattern_i;
                        state_d = mode_i ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                din_d   = mem.mem_out;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                sum_d = sum_q + din_q;
                src_d = src_q + ADDR_W'(1);
                dst_d = dst_q + ADDR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        ld_d   = (state_d == S_WRITE);
        if (state_d == S_READ) begin
            addr_d = src_d;
        end else if (state_d == S_WRITE) begin
            addr_d = dst_d;
            if (mode_d) begin
                din_d = pat_d;
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign checksum_o   = sum_q;
    assign mem.mem_addr = addr_q;
    assign mem.mem_in   = din_q;
    assign mem.mem_ld   = ld_q;

endmodule

// File: tb/tb_ram64_copier.sv
// Directed bench for ram64_copier: a RAM64 model on the bus, a scoreboard of
// expected done cycle/checksum per accepted command, and a done-pulse monitor.
module tb_ram64_copier;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        mode_i;
    logic [5:0]  src_i;
    logic [5:0]  dst_i;
    logic [6:0]  len_i;
    logic [15:0] pattern_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] checksum_o;

    ram64_copier_if #(.ADDR_W(6), .DATA_W(16)) mif ();

    ram64_copier #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .src_i      (src_i),
        .dst_i      (dst_i),
        .len_i      (len_i),
        .pattern_i  (pattern_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .checksum_o (checksum_o),
        .mem        (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM64 model; the bench preload port takes priority over the DUT write
    logic [15:0] ram [64];
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mif.mem_ld) ram[mif.mem_addr] <= mif.mem_in;
    end
    assign mif.mem_out = ram[mif.mem_addr];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [15:0] sum;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int ld_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding command
    always @(negedge clk) begin
        if (rst_n) begin
            if (mif.mem_ld) ld_cnt++;
            if (done_o) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no pending command (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("checksum", 32'(checksum_o), 32'(e.sum));
                    check("busy_at_done", 32'(busy_o), 32'd1);
                end
            end
        end
    end

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Issue one start pulse; accepted commands push their expected result
    task automatic issue(input logic m, input logic [5:0] s, input logic [5:0] d,
                         input logic [6:0] n, input logic [15:0] p,
                         input bit accept, input logic [15:0] esum);
        int unsigned dur;
        @(negedge clk);
        start_i   = 1'b1;
        mode_i    = m;
        src_i     = s;
        dst_i     = d;
        len_i     = n;
        pattern_i = p;
        if (accept) begin
            dur = (n == 0) ? 0 : (m ? 32'(n) : 32'(n) * 2);
            sb.push_back('{cyc: cyc + 1 + dur, sum: esum});
        end
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while ((busy_o || sb.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got busy=%0d pending=%0d expected idle", busy_o, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_mem_ld"}, 32'(mif.mem_ld), 32'd0);
        check({tag, "_mem_addr"}, 32'(mif.mem_addr), 32'd0);
        check({tag, "_mem_in"}, 32'(mif.mem_in), 32'd0);
        check({tag, "_checksum"}, 32'(checksum_o), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start_i   = 1'b0;
        mode_i    = 1'b0;
        src_i     = '0;
        dst_i     = '0;
        len_i     = '0;
        pattern_i = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) preload(6'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 4; i++) preload(6'(i), 16'(i + 1));

        // Copy 0..3 -> 10..13
        ld_cnt = 0;
        issue(1'b0, 6'd0, 6'd10, 7'd4, 16'h0, 1'b1, 16'd10);
        wait_done();
        for (int i = 0; i < 4; i++) check("copy_ram", 32'(ram[10 + i]), 32'(i + 1));
        check("copy_ld_cycles", 32'(ld_cnt), 32'd4);

        // Fill wrapping past 63
        issue(1'b1, 6'd0, 6'd62, 7'd4, 16'hA5A5, 1'b1, 16'h9694);
        wait_done();
        check("fill_ram62", 32'(ram[62]), 32'hA5A5);
        check("fill_ram63", 32'(ram[63]), 32'hA5A5);
        check("fill_ram0", 32'(ram[0]), 32'hA5A5);
        check("fill_ram1", 32'(ram[1]), 32'hA5A5);
        check("fill_ram2_kept", 32'(ram[2]), 32'd3);
        check("fill_ram61_kept", 32'(ram[61]), 32'h103D);

        // Zero-length command
        ld_cnt = 0;
        issue(1'b0, 6'd7, 6'd20, 7'd0, 16'h0, 1'b1, 16'd0);
        wait_done();
        check("len0_ld_cycles", 32'(ld_cnt), 32'd0);

        // Overlapping copy propagates the first word
        preload(6'd5, 16'd7);
        for (int i = 6; i < 9; i++) preload(6'(i), 16'd0);
        issue(1'b0, 6'd5, 6'd6, 7'd3, 16'h0, 1'b1, 16'd21);
        wait_done();
        for (int i = 6; i < 9; i++) check("overlap_ram", 32'(ram[i]), 32'd7);

        // Start while busy is ignored
        issue(1'b0, 6'd10, 6'd50, 7'd4, 16'h0, 1'b1, 16'd10);
        @(negedge clk);
        start_i = 1'b1; mode_i = 1'b1; dst_i = 6'd0; len_i = 7'd5; pattern_i = 16'hFFFF;
        @(negedge clk);
        start_i = 1'b0;
        wait_done();
        for (int i = 0; i < 4; i++) check("ignore_ram", 32'(ram[50 + i]), 32'(i + 1));
        check("ignore_ram0_kept", 32'(ram[0]), 32'hA5A5);
        check("ignore_ram54_kept", 32'(ram[54]), 32'h1036);

        // Reset in the middle of a copy, after the third write
        for (int i = 0; i < 8; i++) preload(6'(20 + i), 16'd100 + 16'(i));
        @(negedge clk);
        start_i = 1'b1; mode_i = 1'b0; src_i = 6'd20; dst_i = 6'd30; len_i = 7'd8;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_mem_ld", 32'(mif.mem_ld), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check("midrst_ram", 32'(ram[30 + i]), 32'(100 + i));
        check("midrst_ram33_kept", 32'(ram[33]), 32'h1021);
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        issue(1'b0, 6'd20, 6'd40, 7'd1, 16'h0, 1'b1, 16'd100);
        wait_done();
        check("post_rst_ram40", 32'(ram[40]), 32'd100);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
